// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and the DE10-Lite memory map.
package ahblite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // HADDR[31:24] match values for the default slave slots
    localparam logic [7:0] MAP_ROM  = 8'h00;
    localparam logic [7:0] MAP_RAM  = 8'h20;
    localparam logic [7:0] MAP_LED  = 8'h50;
    localparam logic [7:0] MAP_UART = 8'h51;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // NONSEQ and SEQ are the only transfer types that demand a response
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers accesses to unmapped space with a two-cycle ERROR.
module ahblite_default_slave
    import ahblite_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT,
    output logic       HRESP
);

    ds_state_t state;
    ds_state_t state_next;

    // State register, cleared asynchronously by reset
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start an ERROR for each active transfer into unmapped space
    always_comb begin
        state_next = state;
        unique case (state)
            DS_IDLE: begin
                if (HREADY && HSEL && trans_active(HTRANS)) begin
                    state_next = DS_ERR1;
                end
            end
            DS_ERR1: begin
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                if (HSEL && trans_active(HTRANS)) begin
                    state_next = DS_ERR1;
                end else begin
                    state_next = DS_IDLE;
                end
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

    // Outputs: wait then complete with ERROR; OKAY with zero wait otherwise
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state)
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            DS_ERR2: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_ERROR;
            end
            default: begin
                HREADYOUT = 1'b1;
                HRESP     = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_decode_mux.sv
// AHB-Lite address decoder and slave response multiplexer with default slave.
module ahblite_decode_mux
    import ahblite_pkg::*;
#(
    parameter int unsigned                 NUM_SLAVES = 4,
    parameter logic [8*NUM_SLAVES-1:0]     SLOT_BASE  = {MAP_UART, MAP_LED, MAP_RAM, MAP_ROM}
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [31:0]              HADDR,
    input  logic [1:0]               HTRANS,
    output logic [NUM_SLAVES-1:0]    HSEL_S,
    input  logic [32*NUM_SLAVES-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]    HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]    HRESP_S,
    output logic [31:0]              HRDATA,
    output logic                     HREADY,
    output logic                     HRESP
);

    logic [NUM_SLAVES-1:0] addr_sel;
    logic                  unmapped;
    logic [NUM_SLAVES:0]   data_sel;
    logic                  ds_ready;
    logic                  ds_resp;
    logic [31:0]           mux_rdata;
    logic                  mux_ready;
    logic                  mux_resp;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^HADDR[23:0];

    // Address-phase decode; the lowest matching slot wins on overlap
    always_comb begin
        logic found;
        found    = 1'b0;
        addr_sel = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!found && (HADDR[31:24] == SLOT_BASE[8*i +: 8])) begin
                addr_sel[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign unmapped = ~|addr_sel;
    assign HSEL_S   = addr_sel;

    // Data-phase select: captured when the bus advances, frozen during stalls
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_sel <= '0;
        end else if (HREADY) begin
            data_sel <= {unmapped, addr_sel};
        end
    end

    ahblite_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (unmapped),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (ds_ready),
        .HRESP     (ds_resp)
    );

    // Response mux; an all-zero select returns an idle OKAY
    always_comb begin
        mux_rdata = '0;
        mux_ready = 1'b1;
        mux_resp  = HRESP_OKAY;
        if (data_sel[NUM_SLAVES]) begin
            mux_ready = ds_ready;
            mux_resp  = ds_resp;
        end
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (data_sel[i]) begin
                mux_rdata = HRDATA_S[32*i +: 32];
                mux_ready = HREADYOUT_S[i];
                mux_resp  = HRESP_S[i];
            end
        end
    end

    assign HRDATA = mux_rdata;
    assign HREADY = mux_ready;
    assign HRESP  = mux_resp;

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Directed bench for ahblite_decode_mux with a transfer-level reference model.
module tb_ahblite_decode_mux;

    localparam int N = 4;
    localparam logic [7:0] BASES [N] = '{8'h00, 8'h20, 8'h50, 8'h51};

    logic           HCLK = 1'b0;
    logic           HRESETn = 1'b0;
    logic [31:0]    HADDR = '0;
    logic [1:0]     HTRANS = 2'b00;
    logic [N-1:0]   HSEL_S;
    logic [32*N-1:0] HRDATA_S = '0;
    logic [N-1:0]   HREADYOUT_S = '1;
    logic [N-1:0]   HRESP_S = '0;
    logic [31:0]    HRDATA;
    logic           HREADY;
    logic           HRESP;

    int errors = 0;
    int checks = 0;

    // Model state: data-phase owner (-1 none, 0..N-1 slave, N default slave)
    // and remaining ERROR response cycles for the default slave.
    int m_slot = -1;
    int m_err  = 0;

    ahblite_decode_mux #(
        .NUM_SLAVES (N),
        .SLOT_BASE  ({8'h51, 8'h50, 8'h20, 8'h00})
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode_idx(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if (a[31:24] == BASES[i]) return i;
        end
        return N;
    endfunction

    function automatic logic [31:0] exp_hsel(input logic [31:0] a);
        int idx;
        idx = decode_idx(a);
        return (idx < N) ? (32'd1 << idx) : 32'd0;
    endfunction

    function automatic logic exp_ready();
        if (m_slot < 0) return 1'b1;
        if (m_slot < N) return HREADYOUT_S[m_slot];
        return m_err != 2;
    endfunction

    function automatic logic exp_resp();
        if (m_slot < 0) return 1'b0;
        if (m_slot < N) return HRESP_S[m_slot];
        return m_err != 0;
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_slot >= 0 && m_slot < N) return HRDATA_S[32*m_slot +: 32];
        return 32'd0;
    endfunction

    // Reference model: a transfer completes when ready; unmapped active ones start an ERROR
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_slot <= -1;
            m_err  <= 0;
        end else begin
            if (exp_ready()) m_slot <= decode_idx(HADDR);
            if (exp_ready() && decode_idx(HADDR) == N && HTRANS[1]) m_err <= 2;
            else if (m_err > 0) m_err <= m_err - 1;
        end
    end

    // Compare process: DUT against model on every falling edge out of reset
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1) begin
            check("model_hsel",   32'(HSEL_S), exp_hsel(HADDR));
            check("model_hready", 32'(HREADY), 32'(exp_ready()));
            check("model_hresp",  32'(HRESP),  32'(exp_resp()));
            check("model_hrdata", HRDATA,      exp_rdata());
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        HADDR  = a;
        HTRANS = t;
        #1;
    endtask

    logic [31:0] tbl_addr [6] = '{32'h0000_0010, 32'h2000_0100, 32'h5000_0000,
                                   32'h5100_0004, 32'h2100_0000, 32'h7F00_0000};
    logic [1:0]  tbl_trans [6] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
    logic [3:0]  tbl_sel [6]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};

    initial begin
        // Reset state
        #1;
        check("reset_hready", 32'(HREADY), 32'd1);
        check("reset_hresp",  32'(HRESP),  32'd0);
        check("reset_hrdata", HRDATA,      32'd0);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        step();

        // LED write: select in address phase, OKAY in data phase
        HRDATA_S[2*32 +: 32] = 32'h0000_00A5;
        drive(32'h5000_0000, 2'b10);
        check("led_hsel", 32'(HSEL_S), 32'h4);
        step();
        drive(32'h0000_0000, 2'b00);
        check("led_hready", 32'(HREADY), 32'd1);
        check("led_hresp",  32'(HRESP),  32'd0);
        check("led_hrdata", HRDATA, 32'h0000_00A5);

        // UART read with two wait states
        drive(32'h5100_0004, 2'b10);
        check("uart_hsel", 32'(HSEL_S), 32'h8);
        step();
        drive(32'h0000_0000, 2'b00);
        HREADYOUT_S[3] = 1'b0;
        HRDATA_S[3*32 +: 32] = 32'hDEAD_0003;
        #1;
        check("uart_wait1", 32'(HREADY), 32'd0);
        step();
        check("uart_wait2", 32'(HREADY), 32'd0);
        step();
        HREADYOUT_S[3] = 1'b1;
        HRDATA_S[3*32 +: 32] = 32'h1234_5678;
        #1;
        check("uart_done_ready", 32'(HREADY), 32'd1);
        check("uart_done_data",  HRDATA, 32'h1234_5678);
        step();

        // Unmapped NONSEQ: two-cycle ERROR then idle
        drive(32'h7000_0000, 2'b10);
        check("unmapped_hsel", 32'(HSEL_S), 32'h0);
        step();
        drive(32'h0000_0000, 2'b00);
        check("err1_ready", 32'(HREADY), 32'd0);
        check("err1_resp",  32'(HRESP),  32'd1);
        step();
        check("err2_ready", 32'(HREADY), 32'd1);
        check("err2_resp",  32'(HRESP),  32'd1);
        step();
        check("after_err_ready", 32'(HREADY), 32'd1);
        check("after_err_resp",  32'(HRESP),  32'd0);

        // IDLE transfer to unmapped space completes OKAY with no wait
        drive(32'h7000_0000, 2'b00);
        step();
        drive(32'h0000_0000, 2'b00);
        check("idle_unmapped_ready", 32'(HREADY), 32'd1);
        check("idle_unmapped_resp",  32'(HRESP),  32'd0);
        step();

        // Back-to-back unmapped NONSEQ: ERR1, ERR2, ERR1, ERR2, IDLE
        drive(32'h7000_0000, 2'b10);
        step();
        drive(32'h7000_0010, 2'b10);
        check("b2b_err1a_ready", 32'(HREADY), 32'd0);
        check("b2b_err1a_resp",  32'(HRESP),  32'd1);
        step();
        check("b2b_err2a_ready", 32'(HREADY), 32'd1);
        check("b2b_err2a_resp",  32'(HRESP),  32'd1);
        step();
        drive(32'h0000_0000, 2'b00);
        check("b2b_err1b_ready", 32'(HREADY), 32'd0);
        check("b2b_err1b_resp",  32'(HRESP),  32'd1);
        step();
        check("b2b_err2b_ready", 32'(HREADY), 32'd1);
        check("b2b_err2b_resp",  32'(HRESP),  32'd1);
        step();
        check("b2b_idle_ready", 32'(HREADY), 32'd1);
        check("b2b_idle_resp",  32'(HRESP),  32'd0);

        // Table of decode patterns with randomised slave responses
        for (int k = 0; k < 6; k++) begin
            HRDATA_S    = {$urandom, $urandom, $urandom, $urandom};
            HREADYOUT_S = 4'($urandom) | 4'b0001;
            HRESP_S     = 4'($urandom);
            drive(tbl_addr[k], tbl_trans[k]);
            check("table_hsel", 32'(HSEL_S), 32'(tbl_sel[k]));
            step();
            HREADYOUT_S = '1;
            step();
        end
        HRESP_S = '0;
        drive(32'h0000_0000, 2'b00);
        for (int k = 0; k < 4; k++) step();

        // Reset asserted during ERR1
        drive(32'h7000_0000, 2'b10);
        step();
        drive(32'h0000_0000, 2'b00);
        check("pre_reset_ready", 32'(HREADY), 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        check("midreset_ready", 32'(HREADY), 32'd1);
        check("midreset_resp",  32'(HRESP),  32'd0);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        HRDATA_S[0 +: 32] = 32'hC0DE_0000;
        drive(32'h0000_0000, 2'b10);
        step();
        drive(32'h0000_0000, 2'b00);
        check("post_reset_rom_data",  HRDATA, 32'hC0DE_0000);
        check("post_reset_rom_ready", 32'(HREADY), 32'd1);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
